// File: rtl/pipe_ctrl_unit.sv
// Stall/flush/bubble controller for an N-stage in-order pipeline.
// Optional saturating perf counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl_unit #(
    parameter int STAGES        = 5,
    parameter int JUMP_DEPTH    = 1,
    parameter int BUBBLE_STAGE  = 2,
    parameter int EXC_FLUSH_CYC = 2,
    parameter int CNT_W         = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [STAGES-1:0] stall_req_i,
    input  logic              fwd_stall_req_i,
    input  logic              jump_flush_req_i,
    input  logic              exc_req_i,
    output logic [STAGES-1:0] stall_o,
    output logic [STAGES-1:0] flush_o,
    output logic              nop_o,
    output logic              exc_busy_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    localparam int EW = (EXC_FLUSH_CYC > 1) ? $clog2(EXC_FLUSH_CYC) : 1;
    localparam logic [EW-1:0] EXC_LOAD = EW'(EXC_FLUSH_CYC - 1);

    typedef enum logic {RUN, EXC_FLUSH} state_t;

    function automatic logic [STAGES-1:0] jump_mask();
        logic [STAGES-1:0] m;
        for (int i = 0; i < STAGES; i++) m[i] = (i < JUMP_DEPTH);
        return m;
    endfunction

    localparam logic [STAGES-1:0] JUMP_MASK = jump_mask();

    state_t            state_p1;
    logic [EW-1:0]     cnt_p1;
    logic [STAGES-1:0] flush_p1;
    logic              busy_p1;

    // Stage 0: combinational stall/bubble decode
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            stall_o[k] = (|(stall_req_i >> k)) | (fwd_stall_req_i && (k < BUBBLE_STAGE));
        end
    end

    assign nop_o = fwd_stall_req_i & ~stall_o[BUBBLE_STAGE];

    // Stage 1: registered flush sequencer
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_p1 <= RUN;
            cnt_p1   <= '0;
            flush_p1 <= '1;
            busy_p1  <= 1'b0;
        end else begin
            case (state_p1)
                RUN: begin
                    if (exc_req_i) begin
                        state_p1 <= EXC_FLUSH;
                        cnt_p1   <= EXC_LOAD;
                        flush_p1 <= '1;
                        busy_p1  <= 1'b1;
                    end else begin
                        flush_p1 <= jump_flush_req_i ? JUMP_MASK : '0;
                        busy_p1  <= 1'b0;
                    end
                end
                EXC_FLUSH: begin
                    if (exc_req_i) begin
                        cnt_p1   <= EXC_LOAD;
                        flush_p1 <= '1;
                        busy_p1  <= 1'b1;
                    end else if (cnt_p1 != '0) begin
                        cnt_p1   <= cnt_p1 - EW'(1);
                        flush_p1 <= '1;
                        busy_p1  <= 1'b1;
                    end else begin
                        // The last flush cycle still honours a jump resolved in it.
                        state_p1 <= RUN;
                        flush_p1 <= jump_flush_req_i ? JUMP_MASK : '0;
                        busy_p1  <= 1'b0;
                    end
                end
                default: begin
                    state_p1 <= RUN;
                    flush_p1 <= '1;
                    busy_p1  <= 1'b0;
                end
            endcase
        end
    end

    assign flush_o    = flush_p1;
    assign exc_busy_o = busy_p1;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_p1;
    logic [CNT_W-1:0] flush_cnt_p1;
    logic             jump_acc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign jump_acc = jump_flush_req_i & ~exc_req_i & ((state_p1 == RUN) | (cnt_p1 == '0));

    // Stage 1: event counters
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stall_cnt_p1 <= '0;
            flush_cnt_p1 <= '0;
        end else begin
            if (stall_o[0]) stall_cnt_p1 <= sat_inc(stall_cnt_p1);
            if (exc_req_i || jump_acc) flush_cnt_p1 <= sat_inc(flush_cnt_p1);
        end
    end

    assign stall_cnt_o = stall_cnt_p1;
    assign flush_cnt_o = flush_cnt_p1;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit: 5 stages, jump depth 2, 2-cycle exception flush, 4-bit counters.
module tb_pipe_ctrl_unit;

    localparam int S  = 5;
    localparam int JD = 2;
    localparam int BS = 2;
    localparam int EC = 2;
    localparam int CW = 4;
    localparam logic [S-1:0] JMASK = 5'b00011;
`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        logic [S-1:0]  f;
        logic          b;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic [S-1:0]  stall_req = '0;
    logic          fwd = 1'b0;
    logic          jmp = 1'b0;
    logic          exc = 1'b0;
    logic [S-1:0]  stall_o;
    logic [S-1:0]  flush_o;
    logic          nop_o;
    logic          exc_busy_o;
    logic [CW-1:0] stall_cnt_o;
    logic [CW-1:0] flush_cnt_o;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   m_left = 0;
    int   m_sc = 0;
    int   m_fc = 0;

    pipe_ctrl_unit #(
        .STAGES(S), .JUMP_DEPTH(JD), .BUBBLE_STAGE(BS), .EXC_FLUSH_CYC(EC), .CNT_W(CW)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .stall_req_i     (stall_req),
        .fwd_stall_req_i (fwd),
        .jump_flush_req_i(jmp),
        .exc_req_i       (exc),
        .stall_o         (stall_o),
        .flush_o         (flush_o),
        .nop_o           (nop_o),
        .exc_busy_o      (exc_busy_o),
        .stall_cnt_o     (stall_cnt_o),
        .flush_cnt_o     (flush_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic [S-1:0] sr, input logic fw,
                        input logic jp, input logic ex);
        exp_t         e;
        logic [S-1:0] es;
        logic         en;
        logic         jacc;
        int           ln;
        @(negedge clk);
        rst_ni = r; stall_req = sr; fwd = fw; jmp = jp; exc = ex;
        #1;
        for (int k = 0; k < S; k++) begin
            es[k] = fw && (k < BS);
            for (int j = k; j < S; j++) if (sr[j]) es[k] = 1'b1;
        end
        en = fw && !es[BS];
        chk("stall_o", 32'(stall_o), 32'(es));
        chk("nop_o", 32'(nop_o), 32'(en));
        if (!r) begin
            m_left = 0; m_sc = 0; m_fc = 0;
            e.f = '1; e.b = 1'b0;
        end else begin
            jacc = jp && !ex && (m_left <= 1);
            ln = ex ? EC : ((m_left > 0) ? m_left - 1 : 0);
            e.f = (ln > 0) ? '1 : (jacc ? JMASK : '0);
            e.b = (ln > 0);
            m_left = ln;
            if (es[0] && m_sc < 15) m_sc++;
            if ((ex || jacc) && m_fc < 15) m_fc++;
        end
        e.sc = PERF ? CW'(m_sc) : '0;
        e.fc = PERF ? CW'(m_fc) : '0;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        chk("sb_depth", 32'(sb_q.size()), 32'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("flush_o", 32'(flush_o), 32'(e.f));
            chk("exc_busy_o", 32'(exc_busy_o), 32'(e.b));
            chk("stall_cnt_o", 32'(stall_cnt_o), 32'(e.sc));
            chk("flush_cnt_o", 32'(flush_cnt_o), 32'(e.fc));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // reset and first cycle after release
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("tp_rst_flush", 32'(flush_o), 32'h1f);
        chk("tp_rst_busy", 32'(exc_busy_o), 32'd0);
        idle(1);
        chk("tp_rst_flush_after", 32'(flush_o), 32'd0);

        // stall propagation and bubble suppression
        step(1'b1, 5'b01000, 1'b0, 1'b0, 1'b0);
        chk("tp_stall_up", 32'(stall_o), 32'h0f);
        step(1'b1, 5'b01000, 1'b1, 1'b0, 1'b0);
        chk("tp_nop_blocked", 32'(nop_o), 32'd0);
        step(1'b1, 5'b00000, 1'b1, 1'b0, 1'b0);
        chk("tp_fwd_stall", 32'(stall_o), 32'h03);
        chk("tp_fwd_nop", 32'(nop_o), 32'd1);

        // jump
        step(1'b1, '0, 1'b0, 1'b1, 1'b0);
        chk("tp_jump", 32'(flush_o), 32'h03);
        idle(2);

        // exception, then back-to-back extension
        step(1'b1, '0, 1'b0, 1'b0, 1'b1);
        idle(3);
        step(1'b1, '0, 1'b0, 1'b0, 1'b1);
        step(1'b1, '0, 1'b0, 1'b0, 1'b1);
        idle(4);

        // simultaneous, jump mid-flush, jump in last flush cycle
        step(1'b1, '0, 1'b0, 1'b1, 1'b1);
        step(1'b1, '0, 1'b0, 1'b1, 1'b0);
        step(1'b1, '0, 1'b0, 1'b1, 1'b0);
        idle(2);

        // reset in the middle of an exception sequence
        step(1'b1, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        idle(2);

        // stall counter saturation
        for (int i = 0; i < 20; i++) step(1'b1, 5'b00001, 1'b0, 1'b0, 1'b0);
        chk("tp_sat", 32'(stall_cnt_o), PERF ? 32'd15 : 32'd0);

        // randomized traffic with occasional reset
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 39) != 0),
                 ($urandom_range(0, 3) == 0) ? S'($urandom) : '0,
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 5) == 0));
        end
        idle(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
